// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: Q8.8 sample type, pooling FSM states, signed max/min and saturating-add helpers.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;

  typedef logic signed [DATA_WIDTH-1:0] q8_8_t;

  typedef enum logic [1:0] {
    POOL_IDLE = 2'd0,
    POOL_RUN  = 2'd1,
    POOL_BP   = 2'd2
  } pool_state_t;

  // Ties keep the first (stored) operand.
  function automatic q8_8_t smax(input q8_8_t stored, input q8_8_t sample);
    return (sample > stored) ? sample : stored;
  endfunction

  function automatic q8_8_t smin(input q8_8_t stored, input q8_8_t sample);
    return (sample < stored) ? sample : stored;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] acc,
                                                    input logic [DATA_WIDTH-1:0] inc);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Per-column partial max/min for the current window row-band; combinational read, one write per cycle.
// load overwrites both halves with the sample, update folds the sample in by signed compare.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int ENTRIES = 31,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          load,
  input  logic          update,
  input  q8_8_t         din,
  output q8_8_t         rd_max,
  output q8_8_t         rd_min
);

  q8_8_t max_mem [ENTRIES];
  q8_8_t min_mem [ENTRIES];

  assign rd_max = max_mem[addr];
  assign rd_min = min_mem[addr];

  always_ff @(posedge clk) begin
    if (load) begin
      max_mem[addr] <= din;
      min_mem[addr] <= din;
    end else if (update) begin
      max_mem[addr] <= smax(max_mem[addr], din);
      min_mem[addr] <= smin(min_mem[addr], din);
    end
  end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming STRIDE x STRIDE max-pool with per-frame max-min loss metric; 1-cycle sample-to-output latency.
// No ready output: enable low in RUN pauses acceptance with all counters and partial windows held.
module max_pool_stream #(
  parameter int INPUT_WIDTH    = 62,
  parameter int INPUT_HEIGHT   = 62,
  parameter int INPUT_CHANNELS = 30,
  parameter int STRIDE         = 2,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] input_data,
  input  logic                         input_valid,
  output logic signed [DATA_WIDTH-1:0] pooled_output,
  output logic                         output_valid,
  output logic                         pool_done,
  output logic        [DATA_WIDTH-1:0] output_error,
  output logic                         backprop_done
);
  import cnn_pkg::*;

  localparam int OUT_W = INPUT_WIDTH / STRIDE;
  localparam int OUT_H = INPUT_HEIGHT / STRIDE;
  localparam int CW    = $clog2(INPUT_WIDTH + 1);
  localparam int RW    = $clog2(INPUT_HEIGHT + 1);
  localparam int HW    = $clog2(INPUT_CHANNELS + 1);
  localparam int SW    = $clog2(STRIDE + 1);
  localparam int WXW   = $clog2(OUT_W + 1);
  localparam int WYW   = $clog2(OUT_H + 1);
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  pool_state_t state_q, state_d;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [HW-1:0]  ch;
  logic [SW-1:0]  sub_col, sub_row;
  logic [WXW-1:0] win_col;
  logic [WYW-1:0] win_row;
  logic [DATA_WIDTH-1:0] loss_acc;

  logic  accept, last_col, last_row, last_ch, last_sample;
  logic  in_region, win_first, win_close;
  q8_8_t rd_max, rd_min, win_max, win_min;
  logic [DATA_WIDTH:0] win_diff;

  assign accept      = (state_q == POOL_RUN) && enable && input_valid;
  assign last_col    = (col == CW'(INPUT_WIDTH - 1));
  assign last_row    = (row == RW'(INPUT_HEIGHT - 1));
  assign last_ch     = (ch == HW'(INPUT_CHANNELS - 1));
  assign last_sample = last_col && last_row && last_ch;

  // Trailing columns/rows past the last full window land outside the pooled region.
  assign in_region = (win_col < WXW'(OUT_W)) && (win_row < WYW'(OUT_H));
  assign win_first = (sub_col == '0) && (sub_row == '0);
  assign win_close = in_region && (sub_col == SW'(STRIDE - 1)) && (sub_row == SW'(STRIDE - 1));

  assign win_max  = win_first ? input_data : smax(rd_max, input_data);
  assign win_min  = win_first ? input_data : smin(rd_min, input_data);
  // max >= min, so the signed difference always fits unsigned in DATA_WIDTH bits.
  assign win_diff = {win_max[DATA_WIDTH-1], win_max} - {win_min[DATA_WIDTH-1], win_min};

  pool_line_buffer #(
    .ENTRIES (OUT_W),
    .AW      (AW)
  ) u_line_buffer (
    .clk    (clk),
    .addr   (win_col[AW-1:0]),
    .load   (accept && in_region && win_first),
    .update (accept && in_region && !win_first),
    .din    (input_data),
    .rd_max (rd_max),
    .rd_min (rd_min)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= POOL_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      POOL_IDLE: if (enable) state_d = POOL_RUN;
      POOL_RUN:  if (accept && last_sample) state_d = POOL_BP;
      POOL_BP:   state_d = POOL_IDLE;
      default:   state_d = POOL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col     <= '0;
      row     <= '0;
      ch      <= '0;
      sub_col <= '0;
      sub_row <= '0;
      win_col <= '0;
      win_row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col     <= '0;
        sub_col <= '0;
        win_col <= '0;
        if (last_row) begin
          row     <= '0;
          sub_row <= '0;
          win_row <= '0;
          ch      <= last_ch ? '0 : ch + 1'b1;
        end else begin
          row <= row + 1'b1;
          if (sub_row == SW'(STRIDE - 1)) begin
            sub_row <= '0;
            win_row <= win_row + 1'b1;
          end else begin
            sub_row <= sub_row + 1'b1;
          end
        end
      end else begin
        col <= col + 1'b1;
        if (sub_col == SW'(STRIDE - 1)) begin
          sub_col <= '0;
          win_col <= win_col + 1'b1;
        end else begin
          sub_col <= sub_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pooled_output <= '0;
      output_valid  <= 1'b0;
      pool_done     <= 1'b0;
      output_error  <= '0;
      backprop_done <= 1'b0;
      loss_acc      <= '0;
    end else begin
      output_valid  <= 1'b0;
      pool_done     <= accept && last_sample;
      backprop_done <= (state_q == POOL_BP);
      if (state_q == POOL_IDLE && enable) loss_acc <= '0;
      if (state_q == POOL_BP) output_error <= loss_acc;
      if (accept && win_close) begin
        pooled_output <= win_max;
        output_valid  <= 1'b1;
        loss_acc      <= sat_add(loss_acc, win_diff[DATA_WIDTH-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Randomized bench for max_pool_stream: a 4x4x1 and a 5x5x2 instance checked against a window-level reference model.
module tb_max_pool_stream;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          en_a, vld_a, en_b, vld_b;
  logic [DW-1:0] dat_a, dat_b;
  logic [DW-1:0] po_a, po_b, oe_a, oe_b;
  logic          ov_a, ov_b, pd_a, pd_b, bd_a, bd_b;

  max_pool_stream #(
    .INPUT_WIDTH(4), .INPUT_HEIGHT(4), .INPUT_CHANNELS(1), .STRIDE(2), .DATA_WIDTH(DW)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .input_data(dat_a), .input_valid(vld_a),
    .pooled_output(po_a), .output_valid(ov_a), .pool_done(pd_a),
    .output_error(oe_a), .backprop_done(bd_a)
  );

  max_pool_stream #(
    .INPUT_WIDTH(5), .INPUT_HEIGHT(5), .INPUT_CHANNELS(2), .STRIDE(2), .DATA_WIDTH(DW)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .input_data(dat_b), .input_valid(vld_b),
    .pooled_output(po_b), .output_valid(ov_b), .pool_done(pd_b),
    .output_error(oe_b), .backprop_done(bd_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors: record every strobe with the clock edge that produced it.
  logic [DW-1:0] got_a[$], got_b[$];
  int            gcyc_a[$], gcyc_b[$];
  int            pd_cnt[2], pd_cyc[2], bd_cyc[2];
  logic [DW-1:0] err_bd[2];

  always @(negedge clk) begin
    if (ov_a) begin got_a.push_back(po_a); gcyc_a.push_back(cyc); end
    if (ov_b) begin got_b.push_back(po_b); gcyc_b.push_back(cyc); end
    if (pd_a) begin pd_cnt[0] <= pd_cnt[0] + 1; pd_cyc[0] <= cyc; end
    if (pd_b) begin pd_cnt[1] <= pd_cnt[1] + 1; pd_cyc[1] <= cyc; end
    if (bd_a) begin bd_cyc[0] <= cyc; err_bd[0] <= oe_a; end
    if (bd_b) begin bd_cyc[1] <= cyc; err_bd[1] <= oe_b; end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] samp[$];
  logic [DW-1:0] exp_q[$];
  int            exp_cyc[$];
  logic [DW-1:0] exp_err;

  // Reference: max/min of each full 2x2 window straight from the sample array.
  task automatic model(input int W, input int H, input int C);
    int acc, mx, mn, v;
    exp_q.delete();
    acc = 0;
    for (int c = 0; c < C; c++)
      for (int oy = 0; oy < H / 2; oy++)
        for (int ox = 0; ox < W / 2; ox++) begin
          mx = -100000;
          mn = 100000;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = $signed(samp[c*H*W + (oy*2 + dy)*W + ox*2 + dx]);
              if (v > mx) mx = v;
              if (v < mn) mn = v;
            end
          exp_q.push_back(mx[DW-1:0]);
          acc = acc + (mx - mn);
          if (acc > 65535) acc = 65535;
        end
    exp_err = acc[DW-1:0];
  endtask

  task automatic set_in(input int w, input logic e, input logic v, input logic [DW-1:0] d);
    if (w == 0) begin en_a = e; vld_a = v; dat_a = d; end
    else        begin en_b = e; vld_b = v; dat_b = d; end
  endtask

  task automatic run_frame(input int w, input int W, input int H, input int C,
                           input bit gaps, input string tag);
    int base, pd0, last_edge, r, cl, n;
    logic [DW-1:0] g;
    int gc;
    n = W * H * C;
    model(W, H, C);
    exp_cyc.delete();
    base = (w == 0) ? got_a.size() : got_b.size();
    pd0  = pd_cnt[w];
    last_edge = 0;
    set_in(w, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          if ($urandom_range(0, 1) == 0) set_in(w, 1'b0, 1'b1, DW'($urandom));
          else                           set_in(w, 1'b1, 1'b0, DW'($urandom));
          @(posedge clk); #1;
        end
      end
      set_in(w, 1'b1, 1'b1, samp[i]);
      @(posedge clk); #1;
      last_edge = cyc;
      cl = i % W;
      r  = (i / W) % H;
      if (cl % 2 == 1 && r % 2 == 1 && cl < (W / 2) * 2 && r < (H / 2) * 2) exp_cyc.push_back(cyc);
    end
    set_in(w, 1'b0, 1'b0, '0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, ((w == 0) ? got_a.size() : got_b.size()) - base, exp_q.size());
    foreach (exp_q[k]) begin
      if (base + k < ((w == 0) ? got_a.size() : got_b.size())) begin
        g  = (w == 0) ? got_a[base + k]  : got_b[base + k];
        gc = (w == 0) ? gcyc_a[base + k] : gcyc_b[base + k];
        check($sformatf("%s_out%0d", tag, k), g, exp_q[k]);
        check($sformatf("%s_lat%0d", tag, k), gc, exp_cyc[k]);
      end
    end
    check({tag, "_pool_done_cnt"}, pd_cnt[w] - pd0, 1);
    check({tag, "_pool_done_cyc"}, pd_cyc[w], last_edge);
    check({tag, "_bp_done_cyc"}, bd_cyc[w], last_edge + 1);
    check({tag, "_err_at_bp"}, err_bd[w], exp_err);
    check({tag, "_err_held"}, (w == 0) ? oe_a : oe_b, exp_err);
  endtask

  task automatic rand_samples(input int n, input bit neg_only);
    samp.delete();
    for (int i = 0; i < n; i++)
      samp.push_back(neg_only ? (DW'($urandom) | 16'h8000) : DW'($urandom));
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 1'b0, 1'b0, '0);
    set_in(1, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pooled", po_a, 0);
    check("rst_error", oe_a, 0);
    check("rst_valid", ov_a, 0);
    check("rst_pool_done", pd_a, 0);
    check("rst_bp_done", bd_a, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    samp.delete();
    for (int i = 0; i < 16; i++) samp.push_back(DW'(i));
    run_frame(0, 4, 4, 1, 1'b0, "raster");
    check("raster_err_20", oe_a, 20);
    check("raster_last_out_15", po_a, 15);

    samp.delete();
    for (int i = 0; i < 16; i++) samp.push_back((i % 2 == 1) ? 16'h8000 : 16'h7FFF);
    run_frame(0, 4, 4, 1, 1'b0, "saturate");
    check("saturate_err_ffff", oe_a, 16'hFFFF);

    for (int f = 0; f < 3; f++) begin
      rand_samples(16, 1'b0);
      run_frame(0, 4, 4, 1, 1'b1, $sformatf("a_rand%0d", f));
    end

    rand_samples(50, 1'b1);
    run_frame(1, 5, 5, 2, 1'b0, "b_negative");
    for (int f = 0; f < 3; f++) begin
      rand_samples(50, 1'b0);
      run_frame(1, 5, 5, 2, 1'b1, $sformatf("b_rand%0d", f));
    end

    // Abort a frame mid-stream after one window has been emitted.
    set_in(0, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1'b1, 1'b1, DW'(i));
      @(posedge clk); #1;
    end
    check("abort_pre_out", po_a, 5);
    set_in(0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_pooled", po_a, 0);
    check("abort_error", oe_a, 0);
    check("abort_valid", ov_a, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    samp.delete();
    for (int i = 0; i < 16; i++) samp.push_back(DW'(i));
    run_frame(0, 4, 4, 1, 1'b0, "after_abort");
    check("after_abort_err_20", oe_a, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
Streaming 2D max-pooling layer of the CNN datapath, placed between conv2d and fully_connected. It consumes conv feature-map samples one per cycle and emits one signed maximum per STRIDE x STRIDE window. After each frame it closes with a one-cycle backprop phase that reports a pooling-loss metric on output_error and pulses backprop_done.

Parameters:
INPUT_WIDTH, 62, feature-map columns
INPUT_HEIGHT, 62, feature-map rows
INPUT_CHANNELS, 30, feature maps per frame
STRIDE, 2, window edge and step (window = STRIDE x STRIDE, non-overlapping)
DATA_WIDTH, 16, sample width, signed Q8.8

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-low
enable  in  1  layer enable; starts a frame from IDLE, gates acceptance in RUN
input_data  in  DATA_WIDTH  input sample, signed
input_valid  in  1  input_data valid this cycle
pooled_output  out  DATA_WIDTH  window maximum, signed
output_valid  out  1  one-cycle strobe qualifying pooled_output
pool_done  out  1  one-cycle pulse: frame pooled
output_error  out  DATA_WIDTH  frame pooling-loss metric, held until next frame starts
backprop_done  out  1  one-cycle pulse: backprop phase complete

Behaviour:
- Reset (reset low at posedge): state=IDLE; all counters 0; pooled_output, output_error = 0; output_valid, pool_done, backprop_done = 0.
- Stream order: channel outermost, then row, then column (raster within channel).
- OUT_W = INPUT_WIDTH/STRIDE, OUT_H = INPUT_HEIGHT/STRIDE (floor). Trailing columns/rows beyond OUT_W*STRIDE / OUT_H*STRIDE are accepted and counted but never pooled.
- FSM: IDLE -> RUN when enable=1 (no sample accepted in that cycle). RUN -> BP on the cycle after the last sample (ch=C-1, row=H-1, col=W-1) is accepted. BP -> IDLE after one cycle.
- Accept: sample accepted in RUN only when enable & input_valid. enable=0 in RUN pauses; counters and buffers hold.
- Line buffer: OUT_W entries each holding partial max and partial min for the current window row-band. The first sample of a window (row%S==0 and col%S==0) loads both. Other samples update both by signed compare.
- Emit: when the accepted sample completes a window (row%S==S-1, col%S==S-1, inside the pooled region), next cycle output_valid=1 and pooled_output=max(partial, sample). pooled_output holds its last value otherwise.
- Loss metric: accumulator of (window max - window min) over all windows. Unsigned, saturating at 2^DATA_WIDTH-1. Cleared on IDLE->RUN.
- pool_done: pulses during the RUN->BP transition cycle, i.e. registered one cycle after the last sample is accepted. It coincides with the last output_valid when the final sample closes a window.
- BP state: output_error <= accumulator; backprop_done pulses next cycle (2 cycles after the last sample accepted).
- Latency: one cycle, sample-in to pooled_output.
- Equal values: max/min ties resolve to the stored value; no effect on output.
- Reset mid-frame: abort immediately to the reset state; partial windows discarded.
- enable held high after BP: a new frame starts (IDLE->RUN next cycle).

Decomposition:
- Shared package cnn_pkg: DATA_WIDTH, Q8.8 fixed-point typedef, signed max/min helper, saturating-add helper.
- One sub-module, pool_line_buffer: OUT_W-entry max/min storage with load/update ports. FSM, counters and metric stay in the top.

Test Plan:
- Params W=H=4, C=1, S=2; input 0..15 raster -> pooled 5,7,13,15 on 4 output_valid strobes; pool_done once; output_error=4*5=20; backprop_done 1 cycle after pool_done.
- Signed data: window {-3,-1,-8,-2} (S=2, W=H=2, C=1) -> pooled_output=0xFFFF (-1); output_error=7.
- Odd size W=H=5, C=1: 25 samples accepted, exactly 4 outputs; row 4 and column 4 ignored; pool_done after 25th sample.
- C=2, W=H=2: two frames of channel data -> 2 outputs in channel order; input_valid toggled randomly and enable dropped mid-frame -> identical outputs, just delayed.
- Saturation: W=H=4, all windows {0x7FFF, 0x8000, ...} -> output_error=0xFFFF.
- Reset asserted after 6 samples -> all outputs 0, state IDLE; a fresh frame then yields results identical to the first test.
